// File: rtl/lcg_multi_pkg.sv
// Shared constants for the multi-lane LCG: default generator constants,
// FSM state encodings and the lane-index width helper.
package lcg_multi_pkg;

  localparam logic [63:0] DEF_MUL   = 64'd69069;
  localparam logic [63:0] DEF_ADD   = 64'd1234567;
  localparam logic [63:0] DEF_SEED0 = 64'd1634404289;

  localparam logic [0:0] ST_WARM = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int WARM_CNT_W = 16;

  // A single-lane build still needs a 1-bit lane index port.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcg_multi_if.sv
// Reseed controls and output stream of the multi-lane LCG.
// The generator is the slave; its controller/consumer is the master.
interface lcg_multi_if
  import lcg_multi_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);

  localparam int CH_W = ch_bits(NUM_CH);

  logic [WIDTH-1:0]        seed;
  logic [CH_W-1:0]         seed_ch;
  logic                    re_seed;
  logic                    re_seed_all;
  logic                    out_ready;
  logic                    out_valid;
  logic [NUM_CH*WIDTH-1:0] rnd;
  logic                    busy;

  modport master (
    output seed, seed_ch, re_seed, re_seed_all, out_ready,
    input  out_valid, rnd, busy
  );

  modport slave (
    input  seed, seed_ch, re_seed, re_seed_all, out_ready,
    output out_valid, rnd, busy
  );

endinterface

// File: rtl/lcg_multi_lane.sv
// One LCG lane: state register with load/advance/hold priority.
module lcg_multi_lane #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MUL     = WIDTH'(69069),
  parameter logic [WIDTH-1:0] ADD     = WIDTH'(1234567),
  parameter logic [WIDTH-1:0] MASK    = '1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] next_state;

  // The low WIDTH bits of MUL*s+ADD do not depend on the discarded high bits,
  // so evaluating at WIDTH bits equals full precision followed by truncation.
  assign next_state = (MUL * state + ADD) & MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_VAL;
    end else if (load) begin
      state <= load_val;
    end else if (advance) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/lcg_multi.sv
// Multi-lane LCG with valid/ready output and warm-up discard after reset
// or broadcast reseed.
module lcg_multi
  import lcg_multi_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] MUL         = DEF_MUL[WIDTH-1:0],
  parameter logic [WIDTH-1:0] ADD         = DEF_ADD[WIDTH-1:0],
  parameter logic [WIDTH-1:0] MASK        = '1,
  parameter logic [WIDTH-1:0] SEED0       = DEF_SEED0[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED_STRIDE = WIDTH'(1),
  parameter int unsigned      WARMUP      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  lcg_multi_if.slave  bus
);

  localparam int                    CH_W      = ch_bits(NUM_CH);
  localparam logic [WARM_CNT_W-1:0] WARM_LOAD = WARM_CNT_W'(WARMUP);
  localparam logic [0:0]            ST_INIT   = (WARMUP > 0) ? ST_WARM : ST_RUN;

  logic [0:0]              fsm;
  logic [WARM_CNT_W-1:0]   warm_cnt;
  logic                    fire;
  logic                    advance;
  logic [NUM_CH*WIDTH-1:0] lane_states;

  assign bus.out_valid = (fsm == ST_RUN);
  assign bus.busy      = (fsm == ST_WARM);
  assign bus.rnd       = lane_states;

  assign fire    = bus.out_valid & bus.out_ready;
  assign advance = (fsm == ST_WARM) | fire;

  // Broadcast reseed restarts the warm-up; single-lane reseed leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= ST_INIT;
      warm_cnt <= WARM_LOAD;
    end else if (bus.re_seed_all) begin
      fsm      <= ST_INIT;
      warm_cnt <= WARM_LOAD;
    end else if (fsm == ST_WARM) begin
      warm_cnt <= warm_cnt - 1'b1;
      if (warm_cnt == WARM_CNT_W'(1)) begin
        fsm <= ST_RUN;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    localparam logic [WIDTH-1:0] OFS = WIDTH'(i) * SEED_STRIDE;

    logic             lane_load;
    logic [WIDTH-1:0] lane_val;

    // Out-of-range seed_ch values match no lane and are therefore ignored.
    assign lane_load = bus.re_seed_all | (bus.re_seed & (bus.seed_ch == CH_W'(i)));
    assign lane_val  = bus.re_seed_all ? (bus.seed + OFS) : bus.seed;

    lcg_multi_lane #(
      .WIDTH   (WIDTH),
      .MUL     (MUL),
      .ADD     (ADD),
      .MASK    (MASK),
      .RST_VAL (SEED0 + OFS)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lane_load),
      .load_val (lane_val),
      .advance  (advance),
      .state    (lane_states[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_lcg_multi.sv
// Scoreboard bench for lcg_multi: a 3-lane 32-bit build with warm-up and a
// 2-lane 16-bit masked build, both checked against an arithmetic model.
module tb_lcg_multi;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int WU = 2;
  localparam longint unsigned MUL    = 69069;
  localparam longint unsigned ADD    = 1234567;
  localparam longint unsigned SEED0  = 1634404289;
  localparam longint unsigned STRIDE = 1;

  typedef struct packed {
    logic         valid;
    logic         busy;
    logic [N*W-1:0] rnd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lcg_multi_if #(.NUM_CH(N), .WIDTH(W))  bus ();
  lcg_multi_if #(.NUM_CH(2), .WIDTH(16)) bus16 ();

  lcg_multi #(.NUM_CH(N), .WIDTH(W), .WARMUP(WU)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  lcg_multi #(.NUM_CH(2), .WIDTH(16), .MASK(16'h7FFF), .WARMUP(0)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  longint unsigned lane_m[N];
  int warm_left;
  longint unsigned m16[2];

  function automatic longint unsigned lcg_step(longint unsigned s, int bits,
                                               longint unsigned mask);
    longint unsigned modulus;
    modulus = 64'd1 << bits;
    return ((MUL * s + ADD) % modulus) & mask;
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    e.valid = (warm_left == 0);
    e.busy  = (warm_left > 0);
    e.rnd   = '0;
    for (int i = 0; i < N; i++) e.rnd[i*W +: W] = lane_m[i][W-1:0];
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) lane_m[i] = (SEED0 + i * STRIDE) & 64'hFFFF_FFFF;
    warm_left = WU;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, steps the model and queues what the DUT
  // must show after the coming edge. Releases reset if it is asserted.
  task automatic applyStimulus(input bit re_all, input bit re, input logic [1:0] ch,
                               input logic [31:0] sd, input bit ready);
    bit adv;
    @(negedge clk);
    bus.re_seed_all = re_all;
    bus.re_seed     = re;
    bus.seed_ch     = ch;
    bus.seed        = sd;
    bus.out_ready   = ready;
    if (!rst_n) begin
      rst_n = 1'b1;
      modelReset();
    end
    checking = 1'b1;
    if (re_all) begin
      for (int i = 0; i < N; i++) lane_m[i] = (sd + i * STRIDE) & 64'hFFFF_FFFF;
      warm_left = WU;
    end else begin
      adv = (warm_left > 0) || ready;
      for (int i = 0; i < N; i++) begin
        if (re && (int'(ch) == i)) lane_m[i] = sd;
        else if (adv) lane_m[i] = lcg_step(lane_m[i], W, 64'hFFFF_FFFF);
      end
      if (warm_left > 0) warm_left--;
    end
    sb.push_back(model_view());
  endtask

  task automatic asyncReset();
    exp_t e;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    modelReset();
    e = model_view();
    #1;
    checkOutput("rst_valid", 128'(bus.out_valid), 128'(e.valid));
    checkOutput("rst_busy",  128'(bus.busy),      128'(e.busy));
    checkOutput("rst_rnd",   128'(bus.rnd),       128'(e.rnd));
    repeat (2) @(negedge clk);
  endtask

  // Monitor for the main DUT: one queued expectation per clock out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && checking) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          checkOutput("out_valid", 128'(bus.out_valid), 128'(e.valid));
          checkOutput("busy",      128'(bus.busy),      128'(e.busy));
          checkOutput("rnd",       128'(bus.rnd),       128'(e.rnd));
        end
      end
    end
  end

  // The 16-bit masked build free-runs with ready tied high.
  initial begin
    bus16.seed        = '0;
    bus16.seed_ch     = '0;
    bus16.re_seed     = 1'b0;
    bus16.re_seed_all = 1'b0;
    bus16.out_ready   = 1'b1;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) m16[i] = (SEED0 + i) & 64'hFFFF;
        else        m16[i] = lcg_step(m16[i], 16, 64'h7FFF);
      end
      #1;
      if (rst_n) begin
        checkOutput("w16_valid", 128'(bus16.out_valid), 128'(1));
        checkOutput("w16_lane0", 128'(bus16.rnd[15:0]),  128'(m16[0]));
        checkOutput("w16_lane1", 128'(bus16.rnd[31:16]), 128'(m16[1]));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    bus.seed        = '0;
    bus.seed_ch     = '0;
    bus.re_seed     = 1'b0;
    bus.re_seed_all = 1'b0;
    bus.out_ready   = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("init_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("init_busy",  128'(bus.busy),      128'(1));
    checkOutput("init_lane0", 128'(bus.rnd[31:0]),  128'(SEED0));
    checkOutput("init_lane2", 128'(bus.rnd[95:64]), 128'(SEED0 + 2));
    repeat (2) @(negedge clk);

    repeat (4) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);

    applyStimulus(1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("warm_first_lane0", 128'(bus.rnd[31:0]), 128'(32'd3667164066));
    checkOutput("warm_first_valid", 128'(bus.out_valid), 128'(1));

    repeat (5) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    repeat (200) applyStimulus(1'b0, 1'b0, 2'd0, $urandom, 1'b1);

    applyStimulus(1'b0, 1'b1, 2'd1, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("reseed_lane1", 128'(bus.rnd[63:32]), 128'(32'hDEADBEEF));
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h1234_5678, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'hCAFE_F00D, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0000_0042, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);

    asyncReset();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
    asyncReset();
    repeat (4) applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);

    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      applyStimulus(r < 2, (r >= 2) && (r < 8), 2'($urandom_range(0, 3)),
                    $urandom, $urandom_range(0, 9) < 7);
    end

    @(posedge clk);
    #2;
    checkOutput("sb_drain", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
